// File: rtl/bscan_spi_bridge_if.sv
// JTAG user-DR and SPI side signals of the BSCAN-to-SPI bridge.
// The host/bench holds the master modport; the bridge holds the slave modport.
interface bscan_spi_bridge_if #(
    parameter int NUM_CS = 4
);
    logic              SEL;
    logic              CAPTURE;
    logic              SHIFT;
    logic              TDI;
    logic              MISO;
    logic              MOSI;
    logic              SCK_EN;
    logic [NUM_CS-1:0] CSB;
    logic              TDO;
    logic              BUSY;
    logic              OVERFLOW;

    modport master (
        output SEL, CAPTURE, SHIFT, TDI, MISO,
        input  MOSI, SCK_EN, CSB, TDO, BUSY, OVERFLOW
    );

    modport slave (
        input  SEL, CAPTURE, SHIFT, TDI, MISO,
        output MOSI, SCK_EN, CSB, TDO, BUSY, OVERFLOW
    );
endinterface

// File: rtl/bscan_spi_bridge.sv
// Bridges a JTAG user DR scan to SPI: hunts a magic header, then forwards TDI
// to MOSI for LEN bits while capturing MISO into a buffer read back on TDO.
module bscan_spi_bridge #(
    parameter int          NUM_CS = 4,
    parameter int          LEN_W  = 16,
    parameter int          BUF_AW = 14,
    parameter logic [31:0] MAGIC  = 32'h59a659a6
) (
    input  logic               DRCK,
    input  logic               RST_N,
    bscan_spi_bridge_if.slave  bus
);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int HW  = 32 + CSW + LEN_W;
    localparam logic [BUF_AW-1:0] ADDR_MAX = '1;
    localparam logic [NUM_CS-1:0] CS_ONE   = NUM_CS'(1);

    typedef enum logic [1:0] {HUNT, XFER, DONE} state_t;

    state_t            state_q, state_nxt;
    logic [HW-1:0]     hdr_q, hdr_nxt;
    logic [NUM_CS-1:0] csb_q, csb_nxt;
    logic [LEN_W-1:0]  cnt_q, cnt_nxt;
    logic [BUF_AW-1:0] rd_addr_q, rd_addr_nxt;
    logic [BUF_AW-1:0] wr_addr_q, wr_addr_nxt;
    logic              wr_full_q, wr_full_nxt;
    logic              ovf_q, ovf_nxt;
    logic              tdo_q, tdo_nxt;
    logic              wr_en;

    logic              buf_mem [0:(2**BUF_AW)-1];

    logic              abort;
    logic [CSW-1:0]    hdr_idx;
    logic [LEN_W-1:0]  hdr_len;
    logic              idx_ok;

    assign abort   = bus.CAPTURE | ~bus.SEL;
    assign hdr_idx = hdr_q[LEN_W +: CSW];
    assign hdr_len = hdr_q[LEN_W-1:0];
    assign idx_ok  = ({1'b0, hdr_idx} < (CSW+1)'(NUM_CS));

    always_comb begin
        state_nxt   = state_q;
        hdr_nxt     = hdr_q;
        csb_nxt     = csb_q;
        cnt_nxt     = cnt_q;
        rd_addr_nxt = rd_addr_q;
        wr_addr_nxt = wr_addr_q;
        wr_full_nxt = wr_full_q;
        ovf_nxt     = ovf_q;
        tdo_nxt     = tdo_q;
        wr_en       = 1'b0;
        if (abort) begin
            // OVERFLOW deliberately survives so the host can read it next scan
            state_nxt   = HUNT;
            hdr_nxt     = '0;
            csb_nxt     = '1;
            cnt_nxt     = '0;
            rd_addr_nxt = '0;
            wr_addr_nxt = '0;
            wr_full_nxt = 1'b0;
        end else if (bus.SHIFT) begin
            tdo_nxt     = buf_mem[rd_addr_q];
            rd_addr_nxt = rd_addr_q + BUF_AW'(1);
            unique case (state_q)
                HUNT: begin
                    if (hdr_q[HW-1 -: 32] == MAGIC) begin
                        ovf_nxt     = 1'b0;
                        wr_addr_nxt = '0;
                        wr_full_nxt = 1'b0;
                        if (hdr_len != '0 && idx_ok) begin
                            state_nxt = XFER;
                            cnt_nxt   = hdr_len;
                            csb_nxt   = ~(CS_ONE << hdr_idx);
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        hdr_nxt = {hdr_q[HW-2:0], bus.TDI};
                    end
                end
                XFER: begin
                    // The last buffer slot is written once; later bits are dropped.
                    if (!wr_full_q) begin
                        wr_en = 1'b1;
                        if (wr_addr_q == ADDR_MAX) wr_full_nxt = 1'b1;
                        else                       wr_addr_nxt = wr_addr_q + BUF_AW'(1);
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    cnt_nxt = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_nxt = DONE;
                        csb_nxt   = '1;
                    end
                end
                DONE:    ;
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge DRCK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= HUNT;
            hdr_q     <= '0;
            csb_q     <= '1;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_full_q <= 1'b0;
            ovf_q     <= 1'b0;
            tdo_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            hdr_q     <= hdr_nxt;
            csb_q     <= csb_nxt;
            cnt_q     <= cnt_nxt;
            rd_addr_q <= rd_addr_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_full_q <= wr_full_nxt;
            ovf_q     <= ovf_nxt;
            tdo_q     <= tdo_nxt;
        end
    end

    // Unreset storage so captured data survives into the next scan.
    always_ff @(posedge DRCK) begin
        if (wr_en) buf_mem[wr_addr_q] <= bus.MISO;
    end

    assign bus.MOSI     = bus.TDI;
    assign bus.BUSY     = (state_q == XFER);
    assign bus.SCK_EN   = (state_q == XFER);
    assign bus.CSB      = csb_q;
    assign bus.TDO      = tdo_q;
    assign bus.OVERFLOW = ovf_q;
endmodule

// File: tb/tb_bscan_spi_bridge.sv
// Scoreboard bench: stimulus pushes per-edge expectations, a monitor pops and
// compares them 1ns after each DRCK rising edge.
module tb_bscan_spi_bridge;
    localparam logic [31:0] MAGIC = 32'h59a659a6;
    localparam logic [3:0] CK_CSB = 4'd1, CK_BUSY = 4'd2, CK_TDO = 4'd4, CK_OVF = 4'd8;

    logic DRCK = 1'b0;
    logic RST_N = 1'b0;
    always #5 DRCK = ~DRCK;

    bscan_spi_bridge_if #(.NUM_CS(4)) ifa ();
    bscan_spi_bridge_if #(.NUM_CS(3)) ifb ();

    bscan_spi_bridge #(.NUM_CS(4)) dut_a (.DRCK(DRCK), .RST_N(RST_N), .bus(ifa.slave));
    bscan_spi_bridge #(.NUM_CS(3), .BUF_AW(4)) dut_b (.DRCK(DRCK), .RST_N(RST_N), .bus(ifb.slave));

    typedef struct {
        int         d;
        string      nm;
        logic [3:0] m;
        logic [3:0] csb;
        logic       busy;
        logic       tdo;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    always begin : mon
        exp_t e;
        logic [3:0] a_csb;
        logic a_busy, a_sck, a_tdo, a_ovf;
        @(posedge DRCK);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d == 0) begin
                a_csb = ifa.CSB; a_busy = ifa.BUSY; a_sck = ifa.SCK_EN;
                a_tdo = ifa.TDO; a_ovf = ifa.OVERFLOW;
            end else begin
                a_csb = {1'b0, ifb.CSB}; a_busy = ifb.BUSY; a_sck = ifb.SCK_EN;
                a_tdo = ifb.TDO; a_ovf = ifb.OVERFLOW;
            end
            if (e.m[0]) check({e.nm, ".csb"}, a_csb, e.csb);
            if (e.m[1]) begin
                check({e.nm, ".busy"}, {3'b0, a_busy}, {3'b0, e.busy});
                check({e.nm, ".sck_en"}, {3'b0, a_sck}, {3'b0, e.busy});
            end
            if (e.m[2]) check({e.nm, ".tdo"}, {3'b0, a_tdo}, {3'b0, e.tdo});
            if (e.m[3]) check({e.nm, ".overflow"}, {3'b0, a_ovf}, {3'b0, e.ovf});
        end
    end

    task automatic drv(int d, logic sel, logic cap, logic sh, logic tdi, logic miso);
        @(negedge DRCK);
        ifa.SEL = (d == 0) ? sel : 1'b0;  ifa.CAPTURE = (d == 0) ? cap : 1'b0;
        ifa.SHIFT = (d == 0) ? sh : 1'b0; ifa.TDI = (d == 0) ? tdi : 1'b0;
        ifa.MISO = (d == 0) ? miso : 1'b0;
        ifb.SEL = (d == 1) ? sel : 1'b0;  ifb.CAPTURE = (d == 1) ? cap : 1'b0;
        ifb.SHIFT = (d == 1) ? sh : 1'b0; ifb.TDI = (d == 1) ? tdi : 1'b0;
        ifb.MISO = (d == 1) ? miso : 1'b0;
    endtask

    task automatic stim(int d, logic sel, logic cap, logic sh, logic tdi, logic miso, string nm,
                        logic [3:0] m, logic [3:0] csb, logic busy, logic tdo, logic ovf);
        exp_t e;
        drv(d, sel, cap, sh, tdi, miso);
        e.d = d; e.nm = nm; e.m = m; e.csb = csb; e.busy = busy; e.tdo = tdo; e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic capture_edge(int d, logic [3:0] hi, logic ovf);
        stim(d, 1, 1, 0, 0, 0, "capture", CK_CSB | CK_BUSY | CK_OVF, hi, 0, 0, ovf);
    endtask

    // Header is MSB first: magic, 2-bit index, 16-bit length (CSW=2 for both DUTs).
    task automatic send_hdr(int d, logic [31:0] mg, int idx, int len, logic [3:0] hi,
                            logic ovf, bit ck_tdo, logic [7:0] tdo_exp);
        logic [49:0] h;
        logic [3:0]  m;
        logic        t;
        h = {mg, 2'(idx), 16'(len)};
        for (int k = 0; k < 50; k++) begin
            m = CK_CSB | CK_BUSY | CK_OVF;
            t = 1'b0;
            if (ck_tdo && k < 8) begin
                m = m | CK_TDO;
                t = tdo_exp[7-k];
            end
            stim(d, 1, 0, 1, h[49-k], 0, "hdr", m, hi, 0, t, ovf);
        end
    endtask

    task automatic xfer_bits(int d, int n, logic [31:0] miso_w, logic [3:0] lo, logic [3:0] hi,
                             int ovf_from);
        for (int i = 1; i <= n; i++)
            stim(d, 1, 0, 1, miso_w[i%2], miso_w[n-i], "xfer", CK_CSB | CK_BUSY | CK_OVF,
                 (i < n) ? lo : hi, (i < n), 0, (ovf_from > 0 && i >= ovf_from));
    endtask

    task automatic idle_edges(int d, int n, logic [3:0] hi, string nm);
        for (int i = 0; i < n; i++)
            stim(d, 1, 0, 1, 1, 1, nm, CK_CSB | CK_BUSY, hi, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        ifa.SEL = 0; ifa.CAPTURE = 0; ifa.SHIFT = 0; ifa.TDI = 0; ifa.MISO = 0;
        ifb.SEL = 0; ifb.CAPTURE = 0; ifb.SHIFT = 0; ifb.TDI = 0; ifb.MISO = 0;
        repeat (3) @(negedge DRCK);
        check("rst.a_csb", ifa.CSB, 4'hF);
        check("rst.b_csb", {1'b0, ifb.CSB}, 4'h7);
        check("rst.a_flags", {ifa.BUSY, ifa.SCK_EN, ifa.TDO, ifa.OVERFLOW}, 4'h0);
        check("rst.b_flags", {ifb.BUSY, ifb.SCK_EN, ifb.TDO, ifb.OVERFLOW}, 4'h0);
        RST_N = 1'b1;

        // Scan 1: idx 2, LEN 8, capture MISO = A5
        capture_edge(0, 4'hF, 0);
        send_hdr(0, MAGIC, 2, 8, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_a1", CK_CSB | CK_BUSY, 4'hB, 1, 0, 0);
        xfer_bits(0, 8, 32'hA5, 4'hB, 4'hF, 0);
        idle_edges(0, 3, 4'hF, "done_a1");

        // Scan 2: LEN 0, readback of A5 from the first shift edge
        capture_edge(0, 4'hF, 0);
        send_hdr(0, MAGIC, 0, 0, 4'hF, 0, 1, 8'hA5);
        stim(0, 1, 0, 1, 0, 0, "pad_len0", CK_CSB | CK_BUSY, 4'hF, 0, 0, 0);
        idle_edges(0, 2, 4'hF, "done_len0");

        // SEL dropped mid transfer, then re-hunt without a capture
        capture_edge(0, 4'hF, 0);
        send_hdr(0, MAGIC, 1, 16, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_idx1", CK_CSB | CK_BUSY, 4'hD, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            stim(0, 1, 0, 1, 1, 0, "xfer_idx1", CK_CSB | CK_BUSY, 4'hD, 1, 0, 0);
        stim(0, 0, 0, 1, 1, 0, "sel_drop", CK_CSB | CK_BUSY, 4'hF, 0, 0, 0);
        send_hdr(0, MAGIC, 0, 1, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_rehunt", CK_CSB | CK_BUSY, 4'hE, 1, 0, 0);
        xfer_bits(0, 1, 32'h1, 4'hE, 4'hF, 0);

        // Corrupted magic never selects a device
        capture_edge(0, 4'hF, 0);
        send_hdr(0, MAGIC ^ 32'h0001_0000, 0, 4, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_bad", CK_CSB | CK_BUSY, 4'hF, 0, 0, 0);
        idle_edges(0, 4, 4'hF, "bad_magic");

        // Asynchronous reset during transfer bit 3
        capture_edge(0, 4'hF, 0);
        send_hdr(0, MAGIC, 3, 8, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_idx3", CK_CSB | CK_BUSY, 4'h7, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            stim(0, 1, 0, 1, 1, 1, "xfer_idx3", CK_CSB | CK_BUSY, 4'h7, 1, 0, 0);
        @(negedge DRCK);
        ifa.SHIFT = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check("async_rst.csb", ifa.CSB, 4'hF);
        check("async_rst.flags", {ifa.BUSY, ifa.SCK_EN, ifa.TDO, ifa.OVERFLOW}, 4'h0);
        @(negedge DRCK);
        RST_N = 1'b1;
        stim(0, 1, 0, 1, 1, 0, "post_rst", CK_CSB | CK_BUSY, 4'hF, 0, 0, 0);
        send_hdr(0, MAGIC, 0, 2, 4'hF, 0, 0, 8'h00);
        stim(0, 1, 0, 1, 0, 0, "pad_post_rst", CK_CSB | CK_BUSY, 4'hE, 1, 0, 0);
        xfer_bits(0, 2, 32'h2, 4'hE, 4'hF, 0);

        // DUT B (NUM_CS=3, 16-bit buffer): overflow on LEN 20
        capture_edge(1, 4'h7, 0);
        send_hdr(1, MAGIC, 0, 20, 4'h7, 0, 0, 8'h00);
        stim(1, 1, 0, 1, 0, 0, "pad_b20", CK_CSB | CK_BUSY | CK_OVF, 4'h6, 1, 0, 0);
        xfer_bits(1, 20, 32'hA5C3F, 4'h6, 4'h7, 17);
        stim(1, 1, 0, 1, 0, 0, "done_b20", CK_CSB | CK_BUSY | CK_OVF, 4'h7, 0, 0, 1);
        capture_edge(1, 4'h7, 1);
        send_hdr(1, MAGIC, 1, 2, 4'h7, 1, 1, 8'hA5);
        stim(1, 1, 0, 1, 0, 0, "pad_b_clr", CK_CSB | CK_BUSY | CK_OVF, 4'h5, 1, 0, 0);
        xfer_bits(1, 2, 32'h3, 4'h5, 4'h7, 0);

        // DUT B: index beyond NUM_CS goes straight to DONE
        capture_edge(1, 4'h7, 0);
        send_hdr(1, MAGIC, 3, 5, 4'h7, 0, 0, 8'h00);
        stim(1, 1, 0, 1, 0, 0, "pad_b_idx3", CK_CSB | CK_BUSY | CK_OVF, 4'h7, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            stim(1, 1, 0, 1, 1, 0, "b_idx3", CK_CSB | CK_BUSY, 4'h7, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) drv(0, 0, 0, 0, 0, 0);
        check("sb_drained", 4'(q.size()), 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bscan_spi_bridge.md
BSCAN_SPI_BRIDGE -- requirements
Module: bscan_spi_bridge

Interface
REQ-001 Parameter NUM_CS, 4, number of SPI chip selects (1..16); CSW = max(1, clog2(NUM_CS)).
REQ-002 Parameter LEN_W, 16, width of header bit-count field.
REQ-003 Parameter BUF_AW, 14, readback buffer address width; depth 2^BUF_AW bits.
REQ-004 Parameter MAGIC, 32'h59a659a6, header sync word; HW = 32+CSW+LEN_W.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 DRCK  input  1  user-DR clock, all state on rising edge.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 SEL  input  1  user DR selected.
REQ-009 CAPTURE  input  1  Capture-DR indicator.
REQ-010 SHIFT  input  1  Shift-DR indicator.
REQ-011 TDI  input  1  JTAG serial data in.
REQ-012 MISO  input  1  SPI serial data from flash.
REQ-013 MOSI  output  1  SPI data out, combinational copy of TDI.
REQ-014 SCK_EN  output  1  high while transfer active; top level gates DRCK to SCK.
REQ-015 CSB  output  NUM_CS  active-low chip selects, at most one low.
REQ-016 TDO  output  1  registered readback bit.
REQ-017 BUSY  output  1  high in state XFER.
REQ-018 OVERFLOW  output  1  sticky: MISO bits dropped because buffer full.

Function
REQ-019 Frame abort: any DRCK edge with CAPTURE=1 or SEL=0 forces state HUNT, HDR=0, CSB all high, RD_ADDR=0, WR_ADDR=0; OVERFLOW held.
REQ-020 States HUNT, XFER, DONE; edges with SHIFT=0 (and no abort) hold all state.
REQ-021 HUNT: each shift edge does HDR <= {HDR[HW-2:0], TDI}, first bit MSB of magic.
REQ-022 Match evaluated on registered HDR: HDR[HW-1:HW-32]==MAGIC; CS index = next CSW bits; LEN = low LEN_W bits (data bit count).
REQ-023 On match edge: OVERFLOW cleared, WR_ADDR=0; LEN!=0 and index<NUM_CS -> XFER, CNT=LEN, CSB[index] low after that edge; otherwise -> DONE, no CSB asserted.
REQ-024 Consequence: bit shifted in the edge that completes HDR plus the match-edge bit are not sent; host inserts exactly one pad bit after header.
REQ-025 XFER: each shift edge writes MISO to BUF[WR_ADDR], WR_ADDR++, CNT--; edge with CNT==1 is last: -> DONE, CSB all high after it.
REQ-026 SCK_EN = BUSY; MOSI tracks TDI unconditionally.
REQ-027 Buffer full: write at WR_ADDR==2^BUF_AW-1 stored, then further writes in that frame dropped, OVERFLOW set; WR_ADDR never wraps; transfer still runs to CNT==0.
REQ-028 DONE: holds until abort; further TDI ignored; no re-hunt within same DR scan.
REQ-029 Readback: every shift edge in any state TDO <= BUF[RD_ADDR], RD_ADDR++ (wraps mod 2^BUF_AW); RD_ADDR reset on abort.
REQ-030 Read/write same address same edge: TDO gets old content (read-first).
REQ-031 Buffer contents survive abort and RST_N; data of scan N readable in scan N+1 from bit 0.
REQ-032 LEN arithmetic unsigned LEN_W bits; LEN = 2^LEN_W-1 legal.

Reset
REQ-033 RST_N low: state HUNT, HDR=0, CSB all high, SCK_EN=0, BUSY=0, TDO=0, OVERFLOW=0, CNT=0, RD_ADDR=0, WR_ADDR=0; buffer not initialised.
REQ-034 RST_N asserted mid-XFER releases CSB within same cycle (asynchronous).
REQ-035 RST_N deassertion recognised on next DRCK rising edge only.

Verification
REQ-036 Defaults, CAPTURE then header magic|idx=2|LEN=8, pad, 8 bits -> CSB=4'b1011 for exactly 8 edges, BUSY mirrors, CSB 4'b1111 after.
REQ-037 MISO=8'hA5 in scan 1; scan 2 header LEN=0 -> TDO returns bits 1,0,1,0,0,1,0,1 from first shift edges, CSB stays 4'b1111.
REQ-038 Header idx=1, LEN=16, SEL dropped after 5 bits -> CSB 4'b1111 next edge, state HUNT, BUSY=0.
REQ-039 BUF_AW=4, LEN=20 -> 16 bits stored, OVERFLOW=1 after 17th edge, CSB low all 20 edges; next matched header clears OVERFLOW.
REQ-040 Corrupt one magic bit -> no CSB ever asserted; NUM_CS=3, idx=3, LEN=5 -> DONE, CSB 3'b111.
REQ-041 RST_N pulsed low at XFER bit 3 -> CSB all high immediately, TDO=0, HUNT after release.
